// File: rtl/lifo_arb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : lifo_arb_pkg                                         |
// | Description : Shared types and constants for the two-requester     |
// |               LIFO arbiter: FSM state encoding, op encoding and    |
// |               default geometry.                                    |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
package lifo_arb_pkg;

  // Arbiter FSM: one operation takes exactly one pass IDLE -> EXEC -> RESP.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  // Per-requester op bit encoding.
  localparam logic OP_PUSH = 1'b1;
  localparam logic OP_POP  = 1'b0;

  // Default geometry (DEPTH must be at least 2).
  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 8;

endpackage : lifo_arb_pkg
`default_nettype wire

// File: rtl/lifo_store.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : lifo_store                                           |
// | Description : Stack storage for the LIFO arbiter. Holds the entry  |
// |               array, occupancy count, full/empty flags and the     |
// |               popped-data register. Push/pop strobes arrive from   |
// |               the arbiter FSM for one cycle; illegal strobes       |
// |               (push when full, pop when empty) are ignored.        |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
module lifo_store
  import lifo_arb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       din_i,
  output logic [WIDTH-1:0]       dout_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, empty_q;
  logic [WIDTH-1:0] dout_q;

  logic             w_push;
  logic             w_pop;
  logic [WIDTH-1:0] w_top;

  // Re-qualify strobes locally so the store can never over/underflow.
  assign w_push = push_i & ~full_q;
  assign w_pop  = pop_i  & ~empty_q;

  // Next occupancy; push and pop are never requested together.
  always_comb begin
    count_d = count_q;
    if (w_push) begin
      count_d = count_q + CW'(1);
    end else if (w_pop) begin
      count_d = count_q - CW'(1);
    end
  end

  // Top-of-stack read mux: the top entry sits at index count-1.
  always_comb begin
    w_top = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (count_q == CW'(i + 1)) begin
        w_top = mem_q[i];
      end
    end
  end

  // Entry array: a legal push writes the slot just above the current top.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (w_push) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (count_q == CW'(i)) begin
          mem_q[i] <= din_i;
        end
      end
    end
  end

  // Occupancy and flags are registered so they change only on an op edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      count_q <= count_d;
      full_q  <= (count_d == CW'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  // Popped data holds until the next legal pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q <= '0;
    end else if (w_pop) begin
      dout_q <= w_top;
    end
  end

  assign dout_o  = dout_q;
  assign count_o = count_q;
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule : lifo_store
`default_nettype wire

// File: rtl/lifo_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : lifo_arbiter                                         |
// | Description : Two-requester round-robin arbiter in front of a      |
// |               shared LIFO stack. Each operation runs IDLE -> EXEC  |
// |               -> RESP (three cycles). gnt pulses in EXEC, done in  |
// |               RESP.                                                |
// |               Optional macro LIFO_ARB_ERR_EN: when defined, an     |
// |               illegal op (push when full / pop when empty) raises  |
// |               err with its done pulse; when undefined err is 0.    |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
module lifo_arbiter
  import lifo_arb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             req,
  input  logic [1:0]             op,
  input  logic [WIDTH-1:0]       din0,
  input  logic [WIDTH-1:0]       din1,
  output logic [1:0]             gnt,
  output logic [1:0]             done,
  output logic [1:0]             err,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  state_e state_q, state_d;
  logic   winner_q, winner_d;   // index of the requester being served
  logic   prio_q, prio_d;       // requester that wins a tie next time

  logic             w_op;
  logic [WIDTH-1:0] w_din;
  logic             w_illegal;
  logic             w_push;
  logic             w_pop;
  logic             w_err_flag;

  // Operands of the current winner; requesters hold them until done.
  assign w_op      = op[winner_q];
  assign w_din     = winner_q ? din1 : din0;
  assign w_illegal = (w_op == OP_PUSH) ? full : empty;

  // FSM registers; reset discards any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      winner_q <= 1'b0;
      prio_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      winner_q <= winner_d;
      prio_q   <= prio_d;
    end
  end

  // Next state, arbitration and per-state output decode.
  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    prio_d   = prio_q;
    gnt      = '0;
    done     = '0;
    err      = '0;
    w_push   = 1'b0;
    w_pop    = 1'b0;
    case (state_q)
      IDLE: begin
        if (req != 2'b00) begin
          // Tie goes to the pointer; a lone request wins outright.
          winner_d = (req == 2'b11) ? prio_q : req[1];
          prio_d   = ~winner_d;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        gnt[winner_q] = 1'b1;
        w_push        = (w_op == OP_PUSH) & ~w_illegal;
        w_pop         = (w_op == OP_POP)  & ~w_illegal;
        state_d       = RESP;
      end
      RESP: begin
        done[winner_q] = 1'b1;
        err[winner_q]  = w_err_flag;
        state_d        = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef LIFO_ARB_ERR_EN
  logic illegal_q;

  // Capture legality at the EXEC edge so it lines up with done in RESP.
  always_ff @(posedge clk) begin
    if (rst) begin
      illegal_q <= 1'b0;
    end else if (state_q == EXEC) begin
      illegal_q <= w_illegal;
    end
  end

  assign w_err_flag = illegal_q;
`else
  assign w_err_flag = 1'b0;
`endif

  lifo_store #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_store (
    .clk     (clk),
    .rst     (rst),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .din_i   (w_din),
    .dout_o  (dout),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );

endmodule : lifo_arbiter
`default_nettype wire

// File: tb/tb_lifo_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module      : tb_lifo_arbiter                                      |
// | Description : Scoreboard bench for lifo_arbiter. Stimulus pushes   |
// |               the expected response of each operation; a monitor   |
// |               compares on every gnt/done pulse. Honours            |
// |               LIFO_ARB_ERR_EN for the expected err value.          |
// | Revision    : 1.0 - initial release                                |
// +--------------------------------------------------------------------+
module tb_lifo_arbiter;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;

`ifdef LIFO_ARB_ERR_EN
  localparam bit ERR_EXP = 1'b1;
`else
  localparam bit ERR_EXP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             r0 = 1'b0, r1 = 1'b0;
  logic             o0 = 1'b0, o1 = 1'b0;
  logic [WIDTH-1:0] din0 = '0, din1 = '0;
  logic [1:0]       req, op;
  logic [1:0]       gnt, done, err;
  logic [WIDTH-1:0] dout;
  logic             full, empty;
  logic [3:0]       count;

  assign req = {r1, r0};
  assign op  = {o1, o0};

  always #5 clk = ~clk;

  lifo_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .op    (op),
    .din0  (din0),
    .din1  (din1),
    .gnt   (gnt),
    .done  (done),
    .err   (err),
    .dout  (dout),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  typedef struct {
    int         who;
    bit         e;
    int         cnt;
    bit         chk_d;
    logic [7:0] d;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_op(input int who, input bit e, input int cnt, input bit chk_d, input logic [7:0] d);
    exp_t x;
    x.who = who; x.e = e; x.cnt = cnt; x.chk_d = chk_d; x.d = d;
    sb.push_back(x);
  endtask

  // Monitor: compare every gnt/done pulse against the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (gnt != 2'b00) begin
        if (sb.size() == 0) begin
          chk("unexpected_gnt", {30'd0, gnt}, 32'd0);
        end else begin
          chk("gnt", {30'd0, gnt}, (sb[0].who == 0) ? 32'd1 : 32'd2);
        end
      end
      if (done != 2'b00) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", {30'd0, done}, 32'd0);
        end else begin
          exp_t x;
          x = sb.pop_front();
          chk("done", {30'd0, done}, (x.who == 0) ? 32'd1 : 32'd2);
          chk("err", {30'd0, err}, x.e ? ((x.who == 0) ? 32'd1 : 32'd2) : 32'd0);
          chk("count", {28'd0, count}, x.cnt);
          chk("full", {31'd0, full}, (x.cnt == DEPTH) ? 32'd1 : 32'd0);
          chk("empty", {31'd0, empty}, (x.cnt == 0) ? 32'd1 : 32'd0);
          if (x.chk_d) chk("dout", {24'd0, dout}, {24'd0, x.d});
        end
      end
    end
  end

  // One requester performing n identical operations, dropping req after each done.
  task automatic drive(input int k, input int n, input logic o, input logic [7:0] d);
    for (int i = 0; i < n; i++) begin
      int cyc;
      if (k == 0) begin r0 = 1'b1; o0 = o; din0 = d; end
      else        begin r1 = 1'b1; o1 = o; din1 = d; end
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
      end while (!done[k] && cyc < 40);
      if (!done[k]) chk("done_timeout", 32'd0, 32'd1);
      if (k == 0) r0 = 1'b0; else r1 = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int cyc;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state.
    chk("rst_gnt", {30'd0, gnt}, 32'd0);
    chk("rst_done", {30'd0, done}, 32'd0);
    chk("rst_err", {30'd0, err}, 32'd0);
    chk("rst_count", {28'd0, count}, 32'd0);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_dout", {24'd0, dout}, 32'd0);

    // Single push, single pop, then pop from empty.
    expect_op(0, 1'b0, 1, 1'b0, 8'h00);
    drive(0, 1, 1'b1, 8'hA5);
    expect_op(1, 1'b0, 0, 1'b1, 8'hA5);
    drive(1, 1, 1'b0, 8'h00);
    expect_op(0, ERR_EXP, 0, 1'b1, 8'hA5);
    drive(0, 1, 1'b0, 8'h00);

    // Reset clears popped data and restores the pointer.
    do_reset();
    chk("rst2_dout", {24'd0, dout}, 32'd0);
    chk("rst2_count", {28'd0, count}, 32'd0);

    // Dual continuous pushes: grants alternate 0,1,... until full.
    for (int i = 0; i < 8; i++) expect_op(i % 2, 1'b0, i + 1, 1'b0, 8'h00);
    fork
      drive(0, 4, 1'b1, 8'h10);
      drive(1, 4, 1'b1, 8'h20);
    join

    // Push while full: rejected, count stays at DEPTH.
    expect_op(0, ERR_EXP, 8, 1'b0, 8'h00);
    drive(0, 1, 1'b1, 8'hFF);

    // Dual pops: requester 1 holds the pointer; data returns 20,10,...
    for (int i = 0; i < 8; i++)
      expect_op((i % 2 == 0) ? 1 : 0, 1'b0, 7 - i, 1'b1, (i % 2 == 0) ? 8'h20 : 8'h10);
    fork
      drive(0, 4, 1'b0, 8'h00);
      drive(1, 4, 1'b0, 8'h00);
    join

    // Pop while empty: dout keeps the last popped value.
    expect_op(0, ERR_EXP, 0, 1'b1, 8'h10);
    drive(0, 1, 1'b0, 8'h00);

    // Reset during EXEC of a push: operation discarded, no done.
    expect_op(0, 1'b0, 1, 1'b0, 8'h00);
    r0 = 1'b1; o0 = 1'b1; din0 = 8'h77;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (gnt != 2'b01 && cyc < 20);
    if (gnt != 2'b01) chk("abort_gnt_timeout", 32'd0, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    r0 = 1'b0;
    chk("abort_done", {30'd0, done}, 32'd0);
    rst = 1'b0;
    sb.delete();
    chk("abort_count", {28'd0, count}, 32'd0);
    chk("abort_empty", {31'd0, empty}, 32'd1);
    repeat (4) @(negedge clk);
    chk("abort_count_later", {28'd0, count}, 32'd0);

    // Next dual request goes to requester 0.
    expect_op(0, 1'b0, 1, 1'b0, 8'h00);
    expect_op(1, 1'b0, 2, 1'b0, 8'h00);
    fork
      drive(0, 1, 1'b1, 8'h11);
      drive(1, 1, 1'b1, 8'h22);
    join

    cyc = 0;
    while (sb.size() != 0 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    if (sb.size() != 0) chk("scoreboard_drain", sb.size(), 32'd0);
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_lifo_arbiter
`default_nettype wire

// File: doc/lifo_arbiter.md
LIFO_ARBITER -- requirements
Module: lifo_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width in bits.
REQ-002 SHALL have parameter DEPTH, default 8, number of stack entries.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req  input  2  per-requester request; bit k belongs to requester k; held high until done[k].
REQ-006 op  input  2  per-requester operation; 1 = push, 0 = pop; held stable while req[k] is high.
REQ-007 din0, din1  input  WIDTH  push data for requester 0 and 1; held stable while req[k] is high.
REQ-008 gnt  output  2  one-hot, high for the single EXEC cycle of the granted requester.
REQ-009 done  output  2  one-hot, single-cycle completion pulse to the granted requester.
REQ-010 err  output  2  error flag, valid only while done[k] is high.
REQ-011 dout  output  WIDTH  popped data, valid while done[k] is high for a pop.
REQ-012 full, empty  output  1  count == DEPTH, count == 0.
REQ-013 count  output  $clog2(DEPTH)+1  current number of stored entries.

Function
REQ-014 SHALL run the FSM IDLE -> EXEC -> RESP -> IDLE; one operation per 3 cycles.
REQ-015 IDLE: no req -> stay IDLE; any req -> latch winner index, go EXEC.
REQ-016 Arbitration: one req -> that requester wins; both -> the requester named by the priority pointer wins.
REQ-017 The priority pointer SHALL move to the other requester after every grant (round-robin); the loser keeps its req and is served next.
REQ-018 EXEC: gnt[winner] = 1; at the closing edge, a legal push writes din<winner> to mem[count] and increments count; a legal pop decrements count and registers mem[count-1] into dout; go RESP.
REQ-019 Push with full = 1, or pop with empty = 1, is illegal and SHALL leave memory, count and dout unchanged.
REQ-020 RESP: done[winner] = 1; err[winner] per Configuration; go IDLE.
REQ-021 The requester SHALL drop req[k] in the cycle after done[k]; a req still high when IDLE samples it is a new request.
REQ-022 dout SHALL hold its last popped value until the next legal pop.
REQ-023 full, empty and count SHALL be registered state, updated at the EXEC closing edge only.
REQ-024 No more than one bit of gnt or done SHALL be high in any cycle.

Reset
REQ-025 rst in any state: FSM -> IDLE; gnt, done, err = 0; count = 0, so empty = 1 and full = 0; dout = 0; all memory entries = 0; priority pointer -> requester 0.
REQ-026 An operation in flight when rst asserts SHALL be discarded with no done pulse; rst has priority over all other inputs.

Configuration
REQ-027 Macro LIFO_ARB_ERR_EN defined: an illegal operation completes with done[k] = 1 and err[k] = 1.
REQ-028 Macro LIFO_ARB_ERR_EN undefined: an illegal operation completes with done[k] = 1; err is tied to 0.
REQ-029 Timing and state behaviour SHALL be identical with and without LIFO_ARB_ERR_EN.

Structure
REQ-030 Package lifo_arb_pkg SHALL hold the FSM state enum (IDLE, EXEC, RESP), the op encoding constants (OP_PUSH = 1, OP_POP = 0) and the default WIDTH and DEPTH.
REQ-031 Sub-module lifo_store SHALL hold memory, count, full, empty and dout, with push/pop strobes from the arbiter FSM.
REQ-032 Arbitration, the priority pointer and the FSM SHALL live in lifo_arbiter.

Verification
REQ-033 Reset, then req = 01, op = 1, din0 = 8'hA5 -> gnt = 01 for 1 cycle, done = 01 for 1 cycle, err = 0, count = 1, empty = 0.
REQ-034 Then req = 10, op = 0 -> done = 10, dout = 8'hA5, count = 0, empty = 1.
REQ-035 Both requesters push continuously from reset (din0 = 8'h10, din1 = 8'h20) -> grants alternate 0, 1, 0, 1; after 8 pushes full = 1; pops then return 20, 10, 20, 10 ...
REQ-036 full = 1, requester 0 pushes 8'hFF -> done = 01, err = 01 (with LIFO_ARB_ERR_EN) or 00 (without); count stays 8; the top entry is unchanged.
REQ-037 empty = 1, pop -> done pulses, dout keeps its previous value, err per macro, count = 0.
REQ-038 Assert rst during EXEC of a push -> no done pulse, count = 0, FSM in IDLE, next dual request granted to requester 0.
